bin2bcd_stream: RTL and testbench

- Parametrised sequential binary-to-packed-BCD converter (shift-and-add-3), the next generation of the team's seven-segment number path.
- Adds configurable width and digit count, an optional signed (two's complement) mode, overflow saturation, a significant-digit count for leading-zero blanking, and valid/ready handshakes on both sides.
- Sits between a numeric producer (counter, ADC, register) and the seven-segment digit mux/driver.

---
 rtl/bin2bcd_stream.sv | 139 +++++++++++++
 tb/tb_bin2bcd_stream.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_stream.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3) with valid/ready on both sides.
// Optional two's complement input, saturation on overflow and a significant-digit count.
module bin2bcd_stream #(
    parameter int NUM_BITS   = 14,
    parameter int NUM_DIGITS = 4,
    parameter bit SIGNED     = 1'b0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_BITS-1:0]               binary_in,
    input  logic                              binary_in_valid,
    output logic                              binary_in_ready,
    output logic [4*NUM_DIGITS-1:0]           packed_bcd_out,
    output logic                              sign_out,
    output logic                              overflow,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   sig_digits,
    output logic                              packed_bcd_out_valid,
    input  logic                              packed_bcd_out_ready
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(NUM_BITS + 1);
    localparam int SD_W  = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_HOLD
    } state_t;

    state_t              state_q;
    logic [NUM_BITS-1:0] mag_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                sign_q;
    logic                nonzero_q;
    logic                ovf_q;
    logic                in_ready_q;
    logic [BCD_W-1:0]    bcd_out_q;
    logic                sign_out_q;
    logic                ovf_out_q;
    logic                valid_q;

    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_d;
    logic [NUM_BITS-1:0] mag_d;
    logic                ovf_d;
    logic                in_neg;
    logic [NUM_BITS-1:0] in_mag;

    // Most negative input negates to itself, which read unsigned is exactly 2^(NUM_BITS-1).
    assign in_neg = SIGNED && binary_in[NUM_BITS-1];
    assign in_mag = in_neg ? (~binary_in + NUM_BITS'(1)) : binary_in;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                        (bcd_q[gi*4 +: 4] + 4'd3) : bcd_q[gi*4 +: 4];
        end
    endgenerate

    assign bcd_d = {bcd_adj[BCD_W-2:0], mag_q[NUM_BITS-1]};
    assign mag_d = {mag_q[NUM_BITS-2:0], 1'b0};
    assign ovf_d = ovf_q | bcd_adj[BCD_W-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mag_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            nonzero_q  <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            bcd_out_q  <= '0;
            sign_out_q <= 1'b0;
            ovf_out_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (binary_in_valid && in_ready_q) begin
                        mag_q      <= in_mag;
                        nonzero_q  <= |binary_in;
                        sign_q     <= in_neg;
                        bcd_q      <= '0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_d;
                    ovf_q <= ovf_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(NUM_BITS - 1)) begin
                        bcd_out_q  <= ovf_d ? {NUM_DIGITS{4'h9}} : bcd_d;
                        ovf_out_q  <= ovf_d;
                        sign_out_q <= sign_q & nonzero_q;
                        valid_q    <= 1'b1;
                        state_q    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (packed_bcd_out_ready) begin
                        valid_q    <= 1'b0;
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b1;
                    valid_q    <= 1'b0;
                end
            endcase
        end
    end

    // Highest nonzero digit wins; an all-zero result still shows one digit.
    always_comb begin
        sig_digits = SD_W'(1);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_out_q[4*i +: 4] != 4'd0) begin
                sig_digits = SD_W'(i + 1);
            end
        end
    end

    assign binary_in_ready      = in_ready_q;
    assign packed_bcd_out       = bcd_out_q;
    assign sign_out             = sign_out_q;
    assign overflow             = ovf_out_q;
    assign packed_bcd_out_valid = valid_q;

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Bench for bin2bcd_stream: unsigned 14-bit/4-digit and signed 8-bit/3-digit instances,
// directed cases plus a random stream checked against a decimal reference model.
module tb_bin2bcd_stream;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [13:0] bin_u = '0;
    logic        vin_u = 1'b0;
    logic        in_rdy_u;
    logic [15:0] bcd_u;
    logic        sign_u;
    logic        ovf_u;
    logic [2:0]  sd_u;
    logic        vout_u;
    logic        ordy_u = 1'b0;

    logic [7:0]  bin_s = '0;
    logic        vin_s = 1'b0;
    logic        in_rdy_s;
    logic [11:0] bcd_s;
    logic        sign_s;
    logic        ovf_s;
    logic [1:0]  sd_s;
    logic        vout_s;
    logic        ordy_s = 1'b0;

    int checks = 0;
    int errors = 0;
    int acc_u  = 0;
    int hs_u   = 0;

    always #5 clk = ~clk;

    bin2bcd_stream #(.NUM_BITS(14), .NUM_DIGITS(4), .SIGNED(1'b0)) u_dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .binary_in            (bin_u),
        .binary_in_valid      (vin_u),
        .binary_in_ready      (in_rdy_u),
        .packed_bcd_out       (bcd_u),
        .sign_out             (sign_u),
        .overflow             (ovf_u),
        .sig_digits           (sd_u),
        .packed_bcd_out_valid (vout_u),
        .packed_bcd_out_ready (ordy_u)
    );

    bin2bcd_stream #(.NUM_BITS(8), .NUM_DIGITS(3), .SIGNED(1'b1)) u_sdut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .binary_in            (bin_s),
        .binary_in_valid      (vin_s),
        .binary_in_ready      (in_rdy_s),
        .packed_bcd_out       (bcd_s),
        .sign_out             (sign_s),
        .overflow             (ovf_s),
        .sig_digits           (sd_s),
        .packed_bcd_out_valid (vout_s),
        .packed_bcd_out_ready (ordy_s)
    );

    always @(posedge clk) begin
        if (reset_n && vin_u && in_rdy_u) acc_u++;
        if (reset_n && vout_u && ordy_u) hs_u++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start(input bit s, input logic [31:0] v);
        int guard = 0;
        @(negedge clk);
        while (!(s ? in_rdy_s : in_rdy_u) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (s) begin bin_s = v[7:0];  vin_s = 1'b1; end
        else   begin bin_u = v[13:0]; vin_u = 1'b1; end
        @(negedge clk);
        vin_s = 1'b0;
        vin_u = 1'b0;
    endtask

    // Called on the falling edge right after the accept edge; returns edges until valid.
    task automatic wait_valid(input bit s, input string tag, input int exp_lat);
        int lat = 0;
        check($sformatf("%s busy", tag), {31'd0, s ? in_rdy_s : in_rdy_u}, 32'd0);
        while (!(s ? vout_s : vout_u) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s latency", tag), lat, exp_lat);
    endtask

    task automatic check_result(input bit s, input logic [31:0] v, input string tag);
        byte         sb;
        int          mag, nd, lim, m, esd;
        bit          neg, eovf;
        logic [15:0] eb;
        if (s) begin
            sb  = v[7:0];
            neg = (sb < 0);
            mag = neg ? -int'(sb) : int'(sb);
            nd  = 3;
        end else begin
            neg = 1'b0;
            mag = int'(v[13:0]);
            nd  = 4;
        end
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        eovf = (mag >= lim);
        eb   = '0;
        m    = mag;
        for (int i = 0; i < nd; i++) begin
            eb[4*i +: 4] = eovf ? 4'd9 : 4'(m % 10);
            m = m / 10;
        end
        if (eovf) esd = nd;
        else begin
            esd = 1;
            m   = mag / 10;
            while (m > 0) begin esd++; m = m / 10; end
        end
        check($sformatf("%s bcd(%0d)", tag, mag), s ? {20'd0, bcd_s} : {16'd0, bcd_u}, {16'd0, eb});
        check($sformatf("%s ovf", tag), {31'd0, s ? ovf_s : ovf_u}, {31'd0, eovf});
        check($sformatf("%s sig_digits", tag), s ? {30'd0, sd_s} : {29'd0, sd_u}, esd);
        check($sformatf("%s sign", tag), {31'd0, s ? sign_s : sign_u}, {31'd0, neg && (mag != 0)});
    endtask

    task automatic handshake(input bit s, input int hold, input string tag);
        repeat (hold) @(negedge clk);
        if (s) ordy_s = 1'b1; else ordy_u = 1'b1;
        @(negedge clk);
        ordy_s = 1'b0;
        ordy_u = 1'b0;
        check($sformatf("%s valid drop", tag), {31'd0, s ? vout_s : vout_u}, 32'd0);
        check($sformatf("%s ready back", tag), {31'd0, s ? in_rdy_s : in_rdy_u}, 32'd1);
    endtask

    task automatic convert(input bit s, input logic [31:0] v, input int hold, input string tag);
        start(s, v);
        wait_valid(s, tag, s ? 8 : 14);
        check_result(s, v, tag);
        handshake(s, hold, tag);
    endtask

    initial begin
        logic [31:0] v;
        int acc0, hs0;

        repeat (2) @(negedge clk);
        check("reset valid", {31'd0, vout_u}, 32'd0);
        check("reset bcd", {16'd0, bcd_u}, 32'd0);
        check("reset sig_digits", {29'd0, sd_u}, 32'd1);
        check("reset flags", {30'd0, ovf_u, sign_u}, 32'd0);
        check("reset ready", {31'd0, in_rdy_u}, 32'd1);
        reset_n = 1'b1;

        convert(1'b0, 32'd9999, 0, "u9999");
        convert(1'b0, 32'd10000, 1, "u10000");
        convert(1'b0, 32'd0, 0, "u0");

        // Backpressure: result must hold while a competing input is offered.
        start(1'b0, 32'd1234);
        wait_valid(1'b0, "bp", 14);
        check_result(1'b0, 32'd1234, "bp");
        bin_u = 14'd777;
        vin_u = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("bp hold %0d", i), {13'd0, vout_u, in_rdy_u, ovf_u, bcd_u},
                  {13'd0, 1'b1, 1'b0, 1'b0, 16'h1234});
        end
        vin_u  = 1'b0;
        ordy_u = 1'b1;
        @(negedge clk);
        ordy_u = 1'b0;
        check("bp valid drop", {31'd0, vout_u}, 32'd0);
        check("bp ready back", {31'd0, in_rdy_u}, 32'd1);
        check("bp keep bcd", {16'd0, bcd_u}, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            bin_u = 14'($urandom);
            @(negedge clk);
            check($sformatf("idle change %0d", i), {15'd0, vout_u, bcd_u}, {16'd0, 16'h1234});
        end

        // Asynchronous reset during conversion bit 7, with overflowed output still shown.
        convert(1'b0, 32'd10000, 0, "pre-rst");
        start(1'b0, 32'd500);
        repeat (7) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst valid", {31'd0, vout_u}, 32'd0);
        check("rst bcd", {16'd0, bcd_u}, 32'd0);
        check("rst ovf", {31'd0, ovf_u}, 32'd0);
        check("rst sig_digits", {29'd0, sd_u}, 32'd1);
        check("rst ready", {31'd0, in_rdy_u}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rst discarded", {31'd0, vout_u}, 32'd0);
        convert(1'b0, 32'd42, 0, "u42");

        convert(1'b1, 32'h80, 0, "s80");
        convert(1'b1, 32'hFF, 2, "sFF");
        convert(1'b1, 32'h7F, 0, "s7F");
        convert(1'b1, 32'h00, 0, "s00");

        acc0 = acc_u;
        hs0  = hs_u;
        for (int n = 0; n < 50; n++) begin
            v = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 9999))
                                            : 32'($urandom_range(0, 16383));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            convert(1'b0, v, $urandom_range(0, 4), $sformatf("rnd%0d", n));
        end
        repeat (2) @(negedge clk);
        check("stream accepts", acc_u - acc0, 50);
        check("stream results", hs_u - hs0, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
